// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Instruction prefetch queue. A fetch PC reads an external combinational
//   instruction ROM and fills a small FIFO of {pc, word} entries. Decode
//   drains the head of the FIFO. A redirect flushes the queue and restarts
//   fetching at a new target. Fetching halts once the PC leaves the ROM.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   a            out  ROM word index {2'b00, pc[31:2]}
//   rd           in   ROM word for a (combinational, same cycle)
//   redirect     in   restart fetch at redirect_pc (flushes queue)
//   redirect_pc  in   byte address of new fetch target
//   inst_valid   out  head entry available
//   inst_ready   in   decode accepts head entry
//   inst         out  head instruction word (0 when empty)
//   inst_pc      out  head byte address (0 when empty)
//   oob          out  fetch PC word index >= ROM_WORDS; fetching halted
//
// Handshake: the head entry transfers on a rising edge where inst_valid and
// inst_ready are both high. inst/inst_pc hold steady while inst_valid is
// high and inst_ready is low. inst_ready only affects the queue state at the
// clock edge; it has no combinational path to a.
// ---------------------------------------------------------------------------
module ifetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          ROM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] a,
    input  logic [31:0] rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        oob
);

    localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
    localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

    // The PC is word aligned, so only the word index is stored.
    logic [29:0]   pc_word;
    logic [29:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_word [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic pop;
    logic push;

    // Low address bits of a redirect target are dropped by alignment.
    logic unused_align;
    assign unused_align = ^redirect_pc[1:0];

    assign a          = {2'b00, pc_word};
    assign oob        = ({2'b00, pc_word} >= ROM_LIMIT);
    assign inst_valid = (count != '0);
    // Gating with inst_valid keeps inst/inst_pc at zero while empty or in
    // reset without needing a reset on the storage array.
    assign inst       = inst_valid ? mem_word[head] : 32'h0;
    assign inst_pc    = inst_valid ? {mem_pc[head], 2'b00} : 32'h0;

    assign pop  = inst_valid && inst_ready;
    assign push = !redirect && !oob && ((count < DEPTH_C) || pop);

    // Queue control and fetch PC. Redirect wins over both push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_word <= RESET_PC[31:2];
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (redirect) begin
            pc_word <= redirect_pc[31:2];
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                pc_word <= pc_word + 30'd1;
                tail    <= (tail == LAST_C) ? '0 : tail + PW'(1);
            end
            if (pop) begin
                head <= (head == LAST_C) ? '0 : head + PW'(1);
            end
            // Push and pop together leave the occupancy unchanged.
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; validity is tracked entirely by head/tail/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail]   <= pc_word;
            mem_word[tail] <= rd;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//   Directed bench for ifetch_queue with a 64-word ROM model holding
//   ROM[i] = i + 0x100. Inputs change on the falling edge; outputs are
//   checked on the falling edge, half a cycle after the active edge.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        oob;

    int n_cmp;
    int n_fail;

    ifetch_queue #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2),
        .ROM_WORDS (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .rd          (rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .oob         (oob)
    );

    // Clock / ROM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd = (a < 32'd64) ? (a + 32'h100) : 32'hDEAD_BEEF;

    // Driver: apply a reset pulse, return at a falling edge with rst_n high.
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        #3;
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        n_cmp++; if (a !== 32'h0) begin n_fail++; $display("FAIL reset_a: got %h want 0", a); end
        n_cmp++; if (oob !== 1'b0) begin n_fail++; $display("FAIL reset_oob: got %b want 0", oob); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", inst_valid); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL first_inst_pc: got %h want 0", inst_pc); end
        n_cmp++; if (inst !== 32'h100) begin n_fail++; $display("FAIL first_inst: got %h want 100", inst); end
        n_cmp++; if (a !== 32'h1) begin n_fail++; $display("FAIL first_a: got %h want 1", a); end
    endtask

    task automatic test_streaming();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, inst_valid); end
            n_cmp++; if (inst_pc !== 32'(k * 4)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, inst_pc, 32'(k * 4)); end
            n_cmp++; if (inst !== 32'(k + 256)) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h want %h", k, inst, 32'(k + 256)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL bp_hold_pc[%0d]: got %h want 0", k, inst_pc); end
            n_cmp++; if (inst !== 32'h100) begin n_fail++; $display("FAIL bp_hold_inst[%0d]: got %h want 100", k, inst); end
        end
        n_cmp++; if (a !== 32'h2) begin n_fail++; $display("FAIL bp_a_sat: got %h want 2", a); end
        inst_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (inst_pc !== 32'(k * 4)) begin n_fail++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", k, inst_pc, 32'(k * 4)); end
            n_cmp++; if (inst !== 32'(k + 256)) begin n_fail++; $display("FAIL bp_drain_inst[%0d]: got %h want %h", k, inst, 32'(k + 256)); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h23;
        @(negedge clk);
        redirect    = 1'b0;
        redirect_pc = 32'hFFFF_FFF0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b want 0", inst_valid); end
        n_cmp++; if (a !== 32'h8) begin n_fail++; $display("FAIL redir_a: got %h want 8", a); end
        @(negedge clk);
        n_cmp++; if (inst_pc !== 32'h20) begin n_fail++; $display("FAIL redir_pc: got %h want 20", inst_pc); end
        n_cmp++; if (inst !== 32'h108) begin n_fail++; $display("FAIL redir_inst: got %h want 108", inst); end
        @(negedge clk);
        n_cmp++; if (inst_pc !== 32'h20) begin n_fail++; $display("FAIL redir_stable: got %h want 20", inst_pc); end
        inst_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (inst_pc !== 32'h24) begin n_fail++; $display("FAIL redir_next_pc: got %h want 24", inst_pc); end
        n_cmp++; if (inst !== 32'h109) begin n_fail++; $display("FAIL redir_next_inst: got %h want 109", inst); end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_flush: got %b want 0", inst_valid); end
        @(negedge clk);
        n_cmp++; if (inst_pc !== 32'h40) begin n_fail++; $display("FAIL rpop_pc0: got %h want 40", inst_pc); end
        n_cmp++; if (inst !== 32'h110) begin n_fail++; $display("FAIL rpop_inst0: got %h want 110", inst); end
        @(negedge clk);
        n_cmp++; if (inst_pc !== 32'h44) begin n_fail++; $display("FAIL rpop_pc1: got %h want 44", inst_pc); end
        n_cmp++; if (inst !== 32'h111) begin n_fail++; $display("FAIL rpop_inst1: got %h want 111", inst); end
    endtask

    task automatic test_oob();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            n_cmp++; if (inst_pc !== 32'(k * 4)) begin n_fail++; $display("FAIL oob_run_pc[%0d]: got %h want %h", k, inst_pc, 32'(k * 4)); end
            if (k == 62) begin
                n_cmp++; if (oob !== 1'b0) begin n_fail++; $display("FAIL oob_early: got %b want 0", oob); end
            end
        end
        n_cmp++; if (inst !== 32'h13F) begin n_fail++; $display("FAIL oob_last_inst: got %h want 13f", inst); end
        n_cmp++; if (oob !== 1'b1) begin n_fail++; $display("FAIL oob_set: got %b want 1", oob); end
        @(negedge clk);
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL oob_drain: got %b want 0", inst_valid); end
        n_cmp++; if (a !== 32'h40) begin n_fail++; $display("FAIL oob_a_hold: got %h want 40", a); end
        @(negedge clk);
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL oob_no_push: got %b want 0", inst_valid); end
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (oob !== 1'b0) begin n_fail++; $display("FAIL oob_clear: got %b want 0", oob); end
        @(negedge clk);
        n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL oob_restart_pc: got %h want 0", inst_pc); end
        n_cmp++; if (inst !== 32'h100) begin n_fail++; $display("FAIL oob_restart_inst: got %h want 100", inst); end
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL areset_inst: got %h want 0", inst); end
        n_cmp++; if (a !== 32'h0) begin n_fail++; $display("FAIL areset_a: got %h want 0", a); end
        @(negedge clk);
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL areset_first_pc: got %h want 0", inst_pc); end
        n_cmp++; if (inst !== 32'h100) begin n_fail++; $display("FAIL areset_first_inst: got %h want 100", inst); end
        @(negedge clk);
        n_cmp++; if (inst_pc !== 32'h4) begin n_fail++; $display("FAIL areset_second_pc: got %h want 4", inst_pc); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_oob();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
